// File: rtl/rf_mp.sv
// rf_mp: parametrised register file with two prioritised write lanes and two registered read ports.
// Optional same-edge write-to-read forwarding is enabled by defining RF_MP_BYPASS_EN.
module rf_mp #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we0,
   input  logic [AW-1:0]    waddr0,
   input  logic [WIDTH-1:0] wdata0,
   input  logic             we1,
   input  logic [AW-1:0]    waddr1,
   input  logic [WIDTH-1:0] wdata1,
   input  logic             re0,
   input  logic [AW-1:0]    raddr0,
   input  logic             re1,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata0,
   output logic             rvalid0,
   output logic [WIDTH-1:0] rdata1,
   output logic             rvalid1
);

   // One extra bit so DEPTH == 2**AW still compares correctly.
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr0_ok;
   logic             wr1_ok;
   logic [WIDTH-1:0] rsel0;
   logic [WIDTH-1:0] rsel1;

   function automatic logic addr_legal(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   function automatic logic [WIDTH-1:0] lookup(input logic [AW-1:0] a);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (a == AW'(i)) v = regs[i];
      end
      return v;
   endfunction

   // Illegal addresses (out of range or the zero register) always read as 0,
   // ahead of any forwarding.
   function automatic logic [WIDTH-1:0] read_sel(input logic [AW-1:0] a);
      logic [WIDTH-1:0] v;
      if (!addr_legal(a)) v = '0;
`ifdef RF_MP_BYPASS_EN
      else if (wr1_ok && (waddr1 == a)) v = wdata1;
      else if (wr0_ok && (waddr0 == a)) v = wdata0;
`endif
      else v = lookup(a);
      return v;
   endfunction

   assign wr0_ok = we0 && addr_legal(waddr0);
   assign wr1_ok = we1 && addr_legal(waddr1);

   // Lane 1 is tested first so it wins a same-address collision.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr1_ok && (waddr1 == AW'(i)))      regs[i] <= wdata1;
            else if (wr0_ok && (waddr0 == AW'(i))) regs[i] <= wdata0;
         end
      end
   end

   always_comb begin
      rsel0 = read_sel(raddr0);
   end

   always_comb begin
      rsel1 = read_sel(raddr1);
   end

   // rvalidN is a one-cycle strobe: high for exactly the cycle following an edge
   // that sampled reN=1; rdataN is only updated on such edges and holds otherwise.
   // There is no backpressure, so a request is always serviced on the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata0  <= '0;
         rvalid0 <= 1'b0;
         rdata1  <= '0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= re0;
         rvalid1 <= re1;
         if (re0) rdata0 <= rsel0;
         if (re1) rdata1 <= rsel1;
      end
   end

endmodule

// File: doc/rf_mp.md
# rf_mp

Parametrised multi-port register file, the next-generation replacement for the 32×64 two-read/one-write file in the datapath. It provides:
- configurable width and depth;
- two write ports with fixed priority;
- two registered read ports with a valid strobe;
- optional hard-wired zero register;
- optional same-cycle write-to-read bypass.

It sits between decode (read requests) and writeback (two retire lanes).

## Interface
Parameters:
- WIDTH, 64, data width in bits
- DEPTH, 32, number of registers (2..256, need not be a power of two)
- AW, 5, address width; must satisfy 2**AW >= DEPTH
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; clears everything while low
- we0  input  1  write enable, lane 0
- waddr0  input  AW  write address, lane 0
- wdata0  input  WIDTH  write data, lane 0
- we1  input  1  write enable, lane 1 (higher priority)
- waddr1  input  AW  write address, lane 1
- wdata1  input  WIDTH  write data, lane 1
- re0  input  1  read request, port 0
- raddr0  input  AW  read address, port 0
- re1  input  1  read request, port 1
- raddr1  input  AW  read address, port 1
- rdata0  output  WIDTH  registered read data, port 0
- rvalid0  output  1  rdata0 updated by last edge
- rdata1  output  WIDTH  registered read data, port 1
- rvalid1  output  1  rdata1 updated by last edge

## Operation
- **Storage:** DEPTH × WIDTH flops.
- **Reset:** reset low asynchronously forces all registers, rdata0/1 and rvalid0/1 to 0. Release is synchronised to clk by the integrator; the block has no internal synchroniser.
- **Writes:** on the rising edge, if weN=1 and waddrN is a legal address, then reg[waddrN] <= wdataN.
- **Write collision:** if we0=we1=1 and waddr0==waddr1, lane 1 wins and lane 0's data is discarded.
- **Illegal write addresses:** waddr >= DEPTH is ignored. With ZERO_REG=1, waddr = 0 is also ignored.
- **Reads:**
  - On the rising edge with reN=1, rdataN <= the selected value and rvalidN <= 1.
  - With reN=0, rvalidN <= 0 and rdataN holds its previous value.
- **Read value selection, in priority order:**
  1. raddr >= DEPTH, or ZERO_REG=1 and raddr = 0: returns 0.
  2. Bypass hit (see Configuration): returns the write data.
  3. Otherwise: returns the pre-edge contents of reg[raddr].
- **Independence:** the two read ports are fully independent and may use the same address.

## Timing
- Read latency is 1 cycle. A request sampled at edge N gives rdata/rvalid valid from edge N through edge N+1.
- Back-to-back reads are allowed every cycle, with no stall or backpressure.
- Write-to-read visibility:
  - Without bypass: a read at edge N+1 sees a write committed at edge N (1-cycle write-to-read distance).
  - With bypass: a read at edge N sees a write at edge N (0-cycle distance).
- reset asserted mid-stream: outputs drop to 0 immediately, not waiting for clk. A read pending at the reset edge is lost.
- The first edge after release behaves normally. Requests at that edge are serviced, returning 0 data unless bypassed.

## Configuration
- Macro: RF_MP_BYPASS_EN.
- **Defined:** same-edge bypass is enabled.
  - If re and we target the same legal, non-zero-reg address at one edge, rdata takes the written data.
  - If both lanes write that address, the bypass takes wdata1 (lane 1 priority).
  - Adds comparators and muxes on the read path.
- **Undefined:** no bypass. A same-edge read returns the old register contents, and the write still commits.

## Test plan
- **Reset:** write 64'hDEAD_BEEF to reg 5, pull reset low between edges, then read reg 5. Expect rdata0 = 0 and rvalid0 = 0 asynchronously while reset is low; after release, a read of reg 5 returns 0.
- **Write collision:** we0=we1=1, waddr0=waddr1=7, wdata0=64'h1, wdata1=64'h2; next cycle read reg 7. Expect rdata = 64'h2 one cycle after the request, with rvalid pulsing exactly one cycle.
- **Zero register:** ZERO_REG=1, write 64'hFFFF to reg 0, then read reg 0 on both ports. Expect rdata0 = rdata1 = 0 and rvalid0 = rvalid1 = 1.
- **Bypass, same edge:** write 64'hA5 to reg 3 while re0=1 and raddr0=3 at the same edge.
  - With RF_MP_BYPASS_EN: expect rdata0 = 64'hA5.
  - Without it: expect the old value (0 after reset), and a read at the next edge returns 64'hA5.
- **Out of range:** DEPTH=24, write 64'h55 to address 30, then read address 30. Expect rdata = 0; all 24 legal registers are unchanged.
- **Streaming:** 32 consecutive cycles of re0=re1=1 on incrementing addresses after filling reg[i] = i. Expect rvalid high continuously and rdataN = raddrN from the previous cycle; then re0=0 drops rvalid0 with rdata0 held.
